// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the iterative multiply sequencer.
//   mult_state_t       - sequencer FSM state encoding
//   MULT_WIDTH_DEFAULT - default operand width
//   mult_cnt_width()   - width of an iteration counter able to hold WIDTH
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mult_state_t;

    localparam int MULT_WIDTH_DEFAULT = 32;

    function automatic int mult_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/mult_seq_datapath.sv
// mult_seq_datapath: operand, accumulator and HI/LO registers for the
// one-bit-per-cycle shift-add multiplier.
//   clk, rst_n            - clock, synchronous active-low reset
//   load                  - latch operands/sign mode, clear accumulator
//   step                  - perform one shift-add iteration
//   fix                   - apply sign to accumulator, write HI/LO
//   mult_sign             - 1 = signed operands
//   operand_a, operand_b  - multiplicand / multiplier
//   hi, lo                - product registers
module mult_seq_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             fix,
    input  logic             mult_sign,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic               neg;
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] product;

    // Negating the most negative value yields itself, which read as unsigned
    // is exactly its magnitude, so no special case is needed.
    always_comb begin
        a_mag   = (mult_sign && operand_a[WIDTH-1]) ? -operand_a : operand_a;
        b_mag   = (mult_sign && operand_b[WIDTH-1]) ? -operand_b : operand_b;
        addend  = mplier[0] ? mcand : '0;
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        product = neg ? -acc : acc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            neg    <= 1'b0;
            acc    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            if (load) begin
                mcand  <= a_mag;
                mplier <= b_mag;
                neg    <= mult_sign & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                acc    <= '0;
            end else if (step) begin
                // Carry out of the upper-half add becomes the new MSB after the shift.
                acc    <= {sum, acc[WIDTH-1:1]};
                mplier <= mplier >> 1;
            end
            if (fix) begin
                hi <= product[2*WIDTH-1:WIDTH];
                lo <= product[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/mult_sequencer.sv
// mult_sequencer: iterative MULT/MULTU controller for the HI/LO unit.
//   clk, rst_n            - clock, synchronous active-low reset
//   start_mult, mult_sign - issue request and signed mode from control
//   operand_a, operand_b  - rs / rt values, sampled with start_mult
//   hilo_read             - MFHI/MFLO in EX
//   hi, lo                - product registers
//   busy                  - multiply in progress
//   done                  - one-cycle pulse when HI/LO were just written
//   stall                 - hold pipeline for reads/new multiplies while busy
//
// state | meaning
// IDLE  | waiting for start_mult; HI/LO stable
// RUN   | WIDTH shift-add iterations
// FIX   | sign correction and HI/LO write
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_mult,
    input  logic             mult_sign,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             hilo_read,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             stall
);

    localparam int CW = mult_cnt_width(WIDTH);

    mult_state_t   state;
    logic [CW-1:0] cnt;
    logic          load;
    logic          step;
    logic          fix;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_mult) begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        load  = (state == IDLE) && start_mult;
        step  = (state == RUN);
        fix   = (state == FIX);
        busy  = (state != IDLE);
        stall = (hilo_read | start_mult) & busy;
    end

    mult_seq_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .fix       (fix),
        .mult_sign (mult_sign),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .hi        (hi),
        .lo        (lo)
    );

endmodule

// File: tb/tb_mult_sequencer.sv
module tb_mult_sequencer;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_mult;
    logic         mult_sign;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         hilo_read;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         busy;
    logic         done;
    logic         stall;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [2*W-1:0] exp_q[$];

    mult_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_mult (start_mult),
        .mult_sign  (mult_sign),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .hilo_read  (hilo_read),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .stall      (stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest queued product.
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                chk("product", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    // Present a request (called mid-cycle) and hold it until accepted.
    // Returns #1 after the accepting edge, with the accept cycle number.
    task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp, output int acc_cyc);
        bit accepted;
        int stall_bad;
        int waited;
        start_mult = 1'b1;
        mult_sign  = sgn;
        operand_a  = a;
        operand_b  = b;
        exp_q.push_back(exp);
        accepted   = 1'b0;
        stall_bad  = 0;
        waited     = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            accepted = !busy;
            if (busy) begin
                waited++;
                if (stall !== 1'b1) stall_bad++;
            end
            @(posedge clk);
            if (accepted) break;
        end
        #1;
        start_mult = 1'b0;
        acc_cyc    = cyc;
        if (!accepted) chk("issue_timeout", 1, 0);
        if (waited > 0) chk("stall_on_start_while_busy", stall_bad, 0);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 1, 0);
    endtask

    typedef struct {
        logic           sgn;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
    } vec_t;

    initial begin
        vec_t vecs[4];
        int   t0, t1, busy_cnt, bad_stall, bad_hold;
        bit   seen;

        vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[1] = '{1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB};
        vecs[2] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[3] = '{1'b0, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};

        rst_n      = 1'b0;
        start_mult = 1'b0;
        mult_sign  = 1'b0;
        operand_a  = '0;
        operand_b  = '0;
        hilo_read  = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_hilo", {hi, lo}, 0);
        chk("reset_flags", {busy, done, stall}, 0);

        // Directed vectors; first one also checks busy length and done timing.
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            issue(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp, t0);
            busy_cnt = 0;
            seen     = 1'b0;
            for (int n = 0; n < 100; n++) begin
                @(negedge clk);
                if (done) begin
                    seen = 1'b1;
                    break;
                end
                if (busy) busy_cnt++;
            end
            if (!seen) chk("done_timeout", 1, 0);
            if (i == 0) begin
                chk("busy_cycles", busy_cnt, 33);
                chk("busy_low_at_done", busy, 0);
            end
        end

        // hilo_read held from 5 cycles after start: stall every busy cycle, old HI/LO hold.
        @(posedge clk); #1;
        issue(1'b1, 32'h0000_0006, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFE2, t0);
        repeat (5) @(posedge clk);
        #1 hilo_read = 1'b1;
        bad_stall = 0;
        bad_hold  = 0;
        seen      = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (stall !== 1'b1) bad_stall++;
            if ({hi, lo} !== 64'h0000_0001_0000_0000) bad_hold++;
        end
        if (!seen) chk("done_timeout", 1, 0);
        chk("stall_on_read_while_busy", bad_stall, 0);
        chk("hilo_hold_during_run", bad_hold, 0);
        chk("no_stall_in_done_cycle", stall, 0);
        chk("read_sees_new_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFE2);
        @(posedge clk); #1 hilo_read = 1'b0;

        // Second start held from 10 cycles into a run: accepted at E(W+2).
        @(posedge clk); #1;
        issue(1'b0, 32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780, t0);
        repeat (10) @(posedge clk);
        #1;
        issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, t1);
        chk("back_to_back_accept_edge", t1 - t0, W + 2);
        wait_done();

        // Reset around iteration 10: run is discarded, no done ever appears.
        @(posedge clk); #1;
        issue(1'b0, 32'h0000_FFFF, 32'h0000_FFFF, 64'h0, t0);
        void'(exp_q.pop_back());
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        hilo_read = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrun_reset_hilo", {hi, lo}, 0);
        chk("midrun_reset_flags", {busy, done, stall}, 0);
        hilo_read = 1'b0;
        repeat (60) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
